// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP camera capture blocks: FSM states, decimation
// width and stream flag bit positions.
package dvp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_ACTIVE     = 2'd2,
    ST_DONE       = 2'd3
  } cap_state_t;

  localparam int DECIM_W  = 2;

  localparam int FLAG_SOF = 0;
  localparam int FLAG_EOL = 1;
  localparam int FLAG_W   = 2;

endpackage

// File: rtl/dvp_input_sync.sv
// Brings the asynchronous DVP pins into the system clock domain and derives
// pclk-rise, href-fall and polarity-corrected vsync-active strobes.
module dvp_input_sync #(
  parameter bit VSYNC_ACT_HI = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_pclk,
  input  logic       i_href,
  input  logic       i_vsync,
  input  logic [7:0] i_db,
  output logic       o_pclk_rise,
  output logic       o_href,
  output logic       o_href_fall,
  output logic       o_vsync_act,
  output logic [7:0] o_db
);

  logic       r_pclk_m, r_pclk_s1, r_pclk_s2;
  logic       r_href_m, r_href_s1, r_href_s2;
  logic       r_vs_m,   r_vs_s1;
  logic [7:0] r_db_m,   r_db_s1;

  // Two flops to reach s1; s2 only exists to give an edge history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pclk_m  <= 1'b0;
      r_pclk_s1 <= 1'b0;
      r_pclk_s2 <= 1'b0;
      r_href_m  <= 1'b0;
      r_href_s1 <= 1'b0;
      r_href_s2 <= 1'b0;
      r_vs_m    <= 1'b0;
      r_vs_s1   <= 1'b0;
      r_db_m    <= 8'd0;
      r_db_s1   <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the previous value.
      r_pclk_m  <= i_pclk;
      r_pclk_s1 <= r_pclk_m;
      r_pclk_s2 <= r_pclk_s1;
      r_href_m  <= i_href;
      r_href_s1 <= r_href_m;
      r_href_s2 <= r_href_s1;
      r_vs_m    <= i_vsync;
      r_vs_s1   <= r_vs_m;
      r_db_m    <= i_db;
      r_db_s1   <= r_db_m;
    end
  end

  assign o_pclk_rise = r_pclk_s1 & ~r_pclk_s2;
  assign o_href      = r_href_s1;
  assign o_href_fall = r_href_s2 & ~r_href_s1;
  assign o_vsync_act = VSYNC_ACT_HI ? r_vs_s1 : ~r_vs_s1;
  assign o_db        = r_db_s1;

endmodule

// File: rtl/dvp_capture_stream.sv
// DVP pixel capture engine: byte assembly, crop window, decimation and a
// single-register valid/ready output with SOF/EOL tags and drop counting.
module dvp_capture_stream
  import dvp_pkg::*;
#(
  parameter int BYTES_PER_PIX = 2,
  parameter int COORD_W       = 10,
  parameter bit VSYNC_ACT_HI  = 1'b1,
  parameter int DROP_CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmos_pclk,
  input  logic                       cmos_href,
  input  logic                       cmos_vsync,
  input  logic [7:0]                 cmos_db,
  input  logic                       cap_en,
  input  logic                       snapshot,
  input  logic                       arm,
  input  logic [COORD_W-1:0]         win_x0,
  input  logic [COORD_W-1:0]         win_x1,
  input  logic [COORD_W-1:0]         win_y0,
  input  logic [COORD_W-1:0]         win_y1,
  input  logic [DECIM_W-1:0]         decim_log2,
  output logic [8*BYTES_PER_PIX-1:0] pix_data,
  output logic                       pix_sof,
  output logic                       pix_eol,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic                       busy,
  output logic                       frame_done,
  output logic [7:0]                 frame_cnt,
  output logic [DROP_CNT_W-1:0]      drop_cnt
);

  localparam int WORD_W = 8 * BYTES_PER_PIX;

  logic       w_pclk_rise, w_href, w_href_fall, w_vs_act;
  logic [7:0] w_db;

  dvp_input_sync #(.VSYNC_ACT_HI(VSYNC_ACT_HI)) u_sync (
    .clk         (clk),
    .rst         (rst),
    .i_pclk      (cmos_pclk),
    .i_href      (cmos_href),
    .i_vsync     (cmos_vsync),
    .i_db        (cmos_db),
    .o_pclk_rise (w_pclk_rise),
    .o_href      (w_href),
    .o_href_fall (w_href_fall),
    .o_vsync_act (w_vs_act),
    .o_db        (w_db)
  );

  cap_state_t r_state, w_state_nxt;
  logic       r_vs_seen;
  logic       w_frame_start, w_frame_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_vs_seen <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_vs_seen <= (r_state == ST_WAIT_FRAME) && (r_vs_seen || w_vs_act);
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    w_state_nxt   = r_state;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    if (!cap_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:       w_state_nxt = ST_WAIT_FRAME;
        ST_WAIT_FRAME: if (r_vs_seen && !w_vs_act) begin
                         w_state_nxt   = ST_ACTIVE;
                         w_frame_start = 1'b1;
                       end
        ST_ACTIVE:     if (w_vs_act) begin
                         w_frame_end = 1'b1;
                         w_state_nxt = snapshot ? ST_DONE : ST_WAIT_FRAME;
                       end
        ST_DONE:       if (arm) w_state_nxt = ST_WAIT_FRAME;
        default:       w_state_nxt = ST_IDLE;
      endcase
    end
  end

  logic [COORD_W-1:0] r_x0, r_x1, r_y0, r_y1, r_x, r_y;
  logic [DECIM_W-1:0] r_decim;
  logic [1:0]         r_byte_idx;
  logic [WORD_W-1:0]  r_shift;
  logic               r_sof_pend;

  logic               w_cap, w_byte_last, w_pix_done, w_keep, w_eol, w_load, w_drop;
  logic [WORD_W-1:0]  w_word;
  logic [COORD_W-1:0] w_step, w_mask, w_dx, w_dy;

  // A vsync edge mid-line aborts the line, so capture is gated on vsync too.
  assign w_cap       = (r_state == ST_ACTIVE) && cap_en && !w_vs_act;
  assign w_byte_last = (r_byte_idx == 2'(BYTES_PER_PIX - 1));
  assign w_word      = (r_shift << 8) | WORD_W'(w_db);
  assign w_pix_done  = w_cap && w_pclk_rise && w_href && w_byte_last;

  assign w_step = COORD_W'(1) << r_decim;
  assign w_mask = w_step - COORD_W'(1);
  assign w_dx   = r_x - r_x0;
  assign w_dy   = r_y - r_y0;
  assign w_keep = w_pix_done && (r_x >= r_x0) && (r_x <= r_x1) &&
                  (r_y >= r_y0) && (r_y <= r_y1) &&
                  ((w_dx & w_mask) == '0) && ((w_dy & w_mask) == '0);
  // Last kept column: the next decimated column would fall past x1.
  assign w_eol  = (r_x1 - r_x) < w_step;
  assign w_load = w_keep && (!pix_valid || pix_ready);
  assign w_drop = w_keep && pix_valid && !pix_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x0       <= '0;
      r_x1       <= '0;
      r_y0       <= '0;
      r_y1       <= '0;
      r_decim    <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
      r_sof_pend <= 1'b0;
    end else if (w_frame_start) begin
      r_x0       <= win_x0;
      r_x1       <= win_x1;
      r_y0       <= win_y0;
      r_y1       <= win_y1;
      r_decim    <= decim_log2;
      r_x        <= '0;
      r_y        <= '0;
      r_byte_idx <= '0;
      r_sof_pend <= 1'b1;
    end else if (!w_cap) begin
      r_x        <= '0;
      r_y        <= '0;
      r_byte_idx <= '0;
    end else begin
      if (w_load) r_sof_pend <= 1'b0;
      if (w_pclk_rise && w_href) begin
        r_shift <= w_word;
        if (w_byte_last) begin
          r_byte_idx <= '0;
          if (r_x != '1) r_x <= r_x + COORD_W'(1);
        end else begin
          r_byte_idx <= r_byte_idx + 2'd1;
        end
      end else if (w_href_fall) begin
        r_byte_idx <= '0;
        r_x        <= '0;
        if (r_y != '1) r_y <= r_y + COORD_W'(1);
      end
    end
  end

  logic [FLAG_W-1:0] r_flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      r_flags    <= '0;
      drop_cnt   <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      if (w_load) begin
        pix_valid          <= 1'b1;
        pix_data           <= w_word;
        r_flags[FLAG_SOF]  <= r_sof_pend;
        r_flags[FLAG_EOL]  <= w_eol;
      end else if (pix_ready) begin
        pix_valid <= 1'b0;
      end
      if (w_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      frame_done <= w_frame_end;
      if (w_frame_end) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign pix_sof = r_flags[FLAG_SOF];
  assign pix_eol = r_flags[FLAG_EOL];
  assign busy    = (r_state == ST_WAIT_FRAME) || (r_state == ST_ACTIVE);

endmodule
